// File: rtl/collision_ctrl.sv
// collision_ctrl
// Takes a snapshot of the player and enemy coordinates on each frame tick.
// It then tests one enemy per cycle for bounding-box overlap with the player.
// It also tracks lives and post-hit invulnerability. Crash is raised at
// game over and freezes the enemy movers until a restart.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   tick                 one-cycle frame strobe
//   restart              one-cycle new-game request (highest priority)
//   player_x/y           player coordinates (12 bit)
//   enemy_x/y            packed enemy coordinates, enemy k at [12k+11:12k]
//   enemy_valid          bit k set: enemy k is collidable
//   crash                game over, held until restart
//   hit_pulse            one-cycle strobe per registered hit
//   hit_idx              index of the last enemy hit
//   lives                remaining lives
//   invul                high while invulnerable
//   dbg_state            current FSM state, for observation only
//
// Handshake: tick and restart are single-cycle strobes with no back-pressure.
// A tick is consumed only in IDLE (starts a scan) or INVUL (counts down).
// It is dropped in any other state or when restart is high.
module collision_ctrl #(
    parameter int N_ENEMY      = 4,
    parameter int HIT_W        = 32,
    parameter int HIT_H        = 32,
    parameter int LIVES        = 3,
    parameter int INVUL_FRAMES = 60
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic                   restart,
    input  logic [11:0]            player_x,
    input  logic [11:0]            player_y,
    input  logic [12*N_ENEMY-1:0]  enemy_x,
    input  logic [12*N_ENEMY-1:0]  enemy_y,
    input  logic [N_ENEMY-1:0]     enemy_valid,
    output logic                   crash,
    output logic                   hit_pulse,
    output logic [2:0]             hit_idx,
    output logic [2:0]             lives,
    output logic                   invul,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_INVUL, ST_OVER} state_t;

    localparam int          CW       = $clog2(INVUL_FRAMES + 1);
    localparam logic [12:0] HIT_W_L  = 13'(HIT_W);
    localparam logic [12:0] HIT_H_L  = 13'(HIT_H);
    localparam logic [2:0]  LIVES_L  = 3'(LIVES);
    localparam logic [2:0]  LAST_IDX = 3'(N_ENEMY - 1);
    localparam logic [CW-1:0] INV_L  = CW'(INVUL_FRAMES);
    localparam logic [CW-1:0] INV_ONE = CW'(1);

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [CW-1:0]          inv_cnt_q, inv_cnt_d;
    logic [11:0]            snap_px_q, snap_px_d;
    logic [11:0]            snap_py_q, snap_py_d;
    logic [12*N_ENEMY-1:0]  snap_ex_q, snap_ex_d;
    logic [12*N_ENEMY-1:0]  snap_ey_q, snap_ey_d;
    logic [N_ENEMY-1:0]     snap_v_q, snap_v_d;
    logic                   crash_q, crash_d;
    logic                   hit_pulse_q, hit_pulse_d;
    logic [2:0]             hit_idx_q, hit_idx_d;
    logic [2:0]             lives_q, lives_d;
    logic                   invul_q, invul_d;

    logic [11:0]            cur_x, cur_y, dx, dy;
    logic                   cur_v, hit;

    function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Select the enemy under test from the snapshot.
    always_comb begin
        cur_x = '0;
        cur_y = '0;
        cur_v = 1'b0;
        for (int k = 0; k < N_ENEMY; k++) begin
            if (idx_q == k[2:0]) begin
                cur_x = snap_ex_q[12*k +: 12];
                cur_y = snap_ey_q[12*k +: 12];
                cur_v = snap_v_q[k];
            end
        end
        dx  = abs_diff(snap_px_q, cur_x);
        dy  = abs_diff(snap_py_q, cur_y);
        // lives_q != 0 keeps the decrement from ever underflowing.
        hit = cur_v && ({1'b0, dx} < HIT_W_L) && ({1'b0, dy} < HIT_H_L) && (lives_q != 3'd0);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        inv_cnt_d   = inv_cnt_q;
        snap_px_d   = snap_px_q;
        snap_py_d   = snap_py_q;
        snap_ex_d   = snap_ex_q;
        snap_ey_d   = snap_ey_q;
        snap_v_d    = snap_v_q;
        crash_d     = crash_q;
        hit_pulse_d = 1'b0;
        hit_idx_d   = hit_idx_q;
        lives_d     = lives_q;
        invul_d     = invul_q;

        if (restart) begin
            state_d   = ST_IDLE;
            idx_d     = 3'd0;
            inv_cnt_d = '0;
            lives_d   = LIVES_L;
            crash_d   = 1'b0;
            invul_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        snap_px_d = player_x;
                        snap_py_d = player_y;
                        snap_ex_d = enemy_x;
                        snap_ey_d = enemy_y;
                        snap_v_d  = enemy_valid;
                        idx_d     = 3'd0;
                        state_d   = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit) begin
                        // First hit ends the scan: lowest index wins.
                        hit_pulse_d = 1'b1;
                        hit_idx_d   = idx_q;
                        lives_d     = lives_q - 3'd1;
                        if (lives_q == 3'd1) begin
                            state_d = ST_OVER;
                            crash_d = 1'b1;
                        end else begin
                            state_d   = ST_INVUL;
                            inv_cnt_d = INV_L;
                            invul_d   = 1'b1;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                ST_INVUL: begin
                    if (tick) begin
                        inv_cnt_d = inv_cnt_q - INV_ONE;
                        if (inv_cnt_q == INV_ONE) begin
                            state_d = ST_IDLE;
                            invul_d = 1'b0;
                        end
                    end
                end
                ST_OVER: begin
                    crash_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            inv_cnt_q   <= '0;
            snap_px_q   <= '0;
            snap_py_q   <= '0;
            snap_ex_q   <= '0;
            snap_ey_q   <= '0;
            snap_v_q    <= '0;
            crash_q     <= 1'b0;
            hit_pulse_q <= 1'b0;
            hit_idx_q   <= 3'd0;
            lives_q     <= LIVES_L;
            invul_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            inv_cnt_q   <= inv_cnt_d;
            snap_px_q   <= snap_px_d;
            snap_py_q   <= snap_py_d;
            snap_ex_q   <= snap_ex_d;
            snap_ey_q   <= snap_ey_d;
            snap_v_q    <= snap_v_d;
            crash_q     <= crash_d;
            hit_pulse_q <= hit_pulse_d;
            hit_idx_q   <= hit_idx_d;
            lives_q     <= lives_d;
            invul_q     <= invul_d;
        end
    end

    assign crash     = crash_q;
    assign hit_pulse = hit_pulse_q;
    assign hit_idx   = hit_idx_q;
    assign lives     = lives_q;
    assign invul     = invul_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_collision_ctrl.sv
// Bench for collision_ctrl with default parameters. A frame-level reference
// model (lives, remaining invulnerable ticks, game-over flag) predicts which
// enemy, if any, is hit on each tick, and the cycle its hit pulse appears.
module tb_collision_ctrl;
    localparam int N     = 4;
    localparam int HW    = 32;
    localparam int HH    = 32;
    localparam int LV    = 3;
    localparam int INV   = 60;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tick = 1'b0;
    logic            restart = 1'b0;
    logic [11:0]     player_x = '0;
    logic [11:0]     player_y = '0;
    logic [12*N-1:0] enemy_x = '0;
    logic [12*N-1:0] enemy_y = '0;
    logic [N-1:0]    enemy_valid = '0;
    logic            crash, hit_pulse, invul;
    logic [2:0]      hit_idx, lives;
    logic [1:0]      dbg_state;

    collision_ctrl #(.N_ENEMY(N), .HIT_W(HW), .HIT_H(HH), .LIVES(LV), .INVUL_FRAMES(INV)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .restart(restart),
        .player_x(player_x), .player_y(player_y),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_valid(enemy_valid),
        .crash(crash), .hit_pulse(hit_pulse), .hit_idx(hit_idx),
        .lives(lives), .invul(invul), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // stimulus fields
    int px, py;
    int ex[N];
    int ey[N];
    logic [N-1:0] ev;

    // reference model
    int m_lives, m_inv, m_idx;
    bit m_over, m_idx_known;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a >= b) ? a - b : b - a;
    endfunction

    task automatic model_reset();
        m_lives = LV; m_inv = 0; m_over = 0; m_idx_known = 0;
    endtask

    task automatic drive_fields();
        player_x = 12'(px);
        player_y = 12'(py);
        for (int k = 0; k < N; k++) begin
            enemy_x[12*k +: 12] = 12'(ex[k]);
            enemy_y[12*k +: 12] = 12'(ey[k]);
        end
        enemy_valid = ev;
    endtask

    task automatic place(input int ppx, input int ppy);
        px = ppx; py = ppy; ev = '0;
        for (int k = 0; k < N; k++) begin ex[k] = 2000; ey[k] = 2000; end
    endtask

    task automatic check_state(input string tag);
        if (m_idx_known) chk({tag, "_hit_idx"}, 32'(hit_idx), m_idx);
        chk({tag, "_lives"}, 32'(lives), m_lives);
        chk({tag, "_invul"}, 32'(invul), (m_inv > 0));
        chk({tag, "_crash"}, 32'(crash), m_over);
    endtask

    // One frame: predict, issue tick, watch hit_pulse, check outputs.
    task automatic frame(input string tag);
        int exp_k, cnt, pos;
        exp_k = -1;
        if (!m_over) begin
            if (m_inv > 0) m_inv--;
            else begin
                for (int k = 0; k < N; k++)
                    if (exp_k < 0 && ev[k] && absd(px, ex[k]) < HW && absd(py, ey[k]) < HH) exp_k = k;
                if (exp_k >= 0) begin
                    m_lives--; m_idx = exp_k; m_idx_known = 1;
                    if (m_lives == 0) m_over = 1; else m_inv = INV;
                end
            end
        end
        @(negedge clk);
        drive_fields();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        cnt = 0; pos = -1;
        for (int j = 0; j <= N + 2; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            if (hit_pulse === 1'b1) begin cnt++; if (pos < 0) pos = j; end
        end
        chk({tag, "_pulse_cnt"}, cnt, (exp_k >= 0) ? 1 : 0);
        if (exp_k >= 0) chk({tag, "_pulse_pos"}, pos, exp_k + 1);
        check_state(tag);
    endtask

    task automatic do_restart(input string tag);
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        model_reset();
        chk({tag, "_pulse"}, 32'(hit_pulse), 0);
        check_state(tag);
    endtask

    initial begin
        int cnt;
        model_reset();
        m_idx = 0; m_idx_known = 1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset_pulse", 32'(hit_pulse), 0);
        @(negedge clk) rst_n = 1'b1;

        // Threshold in x: dx=32 misses, dx=31 hits
        place(640, 360); ex[0] = 672; ey[0] = 360; ev = 4'b0001;
        frame("dx32");
        ex[0] = 671;
        frame("dx31");
        do_restart("rst1");

        // No wrap on absolute difference
        place(10, 10); ex[0] = 0; ey[0] = 0; ev = 4'b0001;
        frame("nowrap");
        do_restart("rst2");

        // Basic hit
        place(640, 360); ex[0] = 650; ey[0] = 370; ev = 4'b0001;
        frame("basic");
        do_restart("rst3");

        // Priority and valid: enemy 0 overlaps but invalid; 1 and 3 overlap
        place(640, 360);
        ex[0] = 640; ey[0] = 360;
        ex[1] = 630; ey[1] = 350;
        ex[3] = 645; ey[3] = 365;
        ev = 4'b1010;
        frame("prio");

        // Invulnerability with persistent overlap, then second and third hits
        for (int t = 0; t < INV + 1; t++) frame("invul_a");
        for (int t = 0; t < INV + 1; t++) frame("invul_b");
        // Game over held
        for (int t = 0; t < 100; t++) frame("over");
        do_restart("rst4");

        // Restart coincident with a hit on enemy 0
        place(640, 360); ex[0] = 640; ey[0] = 360; ev = 4'b0001;
        @(negedge clk);
        drive_fields();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        model_reset();
        cnt = 0;
        for (int j = 0; j < N + 2; j++) begin
            if (hit_pulse === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        chk("rst_hit_pulses", cnt, 0);
        check_state("rst_hit");

        // Reset mid-scan with lives below the reset value
        frame("pre_reset_hit");
        ev = '0;
        for (int t = 0; t < INV; t++) frame("pre_reset_inv");
        place(640, 360); ex[3] = 640; ey[3] = 360; ev = 4'b1000;
        @(negedge clk);
        drive_fields();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midscan_lives", 32'(lives), LV);
        chk("midscan_crash", 32'(crash), 0);
        chk("midscan_invul", 32'(invul), 0);
        chk("midscan_pulse", 32'(hit_pulse), 0);
        @(negedge clk) rst_n = 1'b1;
        cnt = 0;
        for (int j = 0; j < N + 2; j++) begin
            @(posedge clk); #1;
            if (hit_pulse === 1'b1) cnt++;
        end
        chk("midscan_discard", cnt, 0);
        place(640, 360); ex[0] = 641; ey[0] = 359; ev = 4'b0001;
        frame("post_reset");

        // Randomized frames near the player, with occasional restarts
        for (int t = 0; t < 200; t++) begin
            px = $urandom_range(0, 4095);
            py = $urandom_range(0, 4095);
            for (int k = 0; k < N; k++) begin
                ex[k] = (px + int'($urandom_range(0, 80)) - 40) & 12'hFFF;
                ey[k] = (py + int'($urandom_range(0, 80)) - 40) & 12'hFFF;
            end
            ev = N'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) do_restart("rnd_rst");
            frame("rnd");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
